sync_fifo_flags: RTL and testbench

//  Single-clock parametrised FIFO, successor to the dual-clock FIFO. Used where producer and consumer share a clock.

---
 rtl/sync_fifo_flags_if.sv | 28 ++
 rtl/sync_fifo_flags.sv | 107 ++++++++++
 tb/tb_sync_fifo_flags.sv | 170 +++++++++++++++++
 3 files changed

// File: rtl/sync_fifo_flags_if.sv
// rtl/sync_fifo_flags_if.sv - Producer/consumer bundle for sync_fifo_flags
interface sync_fifo_flags_if #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 3
);
    logic                  clr;
    logic                  w_en;
    logic [DATA_WIDTH-1:0] w_data;
    logic                  r_en;
    logic [DATA_WIDTH-1:0] r_data;
    logic                  full;
    logic                  empty;
    logic                  almost_full;
    logic                  almost_empty;
    logic [ADDR_WIDTH:0]   count;
    logic                  overflow;
    logic                  underflow;

    modport master (
        output clr, w_en, w_data, r_en,
        input  r_data, full, empty, almost_full, almost_empty, count, overflow, underflow
    );

    modport slave (
        input  clr, w_en, w_data, r_en,
        output r_data, full, empty, almost_full, almost_empty, count, overflow, underflow
    );
endinterface

// File: rtl/sync_fifo_flags.sv
// rtl/sync_fifo_flags.sv - Single-clock FIFO with level, threshold and sticky error flags
module sync_fifo_flags #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 3,
    parameter int AF_THRESH  = 6,
    parameter int AE_THRESH  = 1,
    parameter int FWFT       = 0
) (
    input  logic               clk,
    input  logic               rst_n,
    sync_fifo_flags_if.slave   bus
);
    localparam int                  DEPTH   = 1 << ADDR_WIDTH;
    localparam logic [ADDR_WIDTH:0] DEPTH_C = DEPTH[ADDR_WIDTH:0];
    localparam logic [ADDR_WIDTH:0] AF_C    = AF_THRESH[ADDR_WIDTH:0];
    localparam logic [ADDR_WIDTH:0] AE_C    = AE_THRESH[ADDR_WIDTH:0];

    if (AF_THRESH < 1 || AF_THRESH > DEPTH) begin : g_bad_af
        $error("sync_fifo_flags: AF_THRESH out of range 1..DEPTH");
    end
    if (AE_THRESH < 0 || AE_THRESH > DEPTH - 1) begin : g_bad_ae
        $error("sync_fifo_flags: AE_THRESH out of range 0..DEPTH-1");
    end

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [ADDR_WIDTH-1:0] wr_ptr;
    logic [ADDR_WIDTH-1:0] rd_ptr;
    logic [ADDR_WIDTH:0]   count_q;
    logic                  overflow_q;
    logic                  underflow_q;
    logic                  full_q;
    logic                  empty_q;
    logic                  wr_acc;
    logic                  rd_acc;

    // Flags decode only the registered count so request inputs never reach them combinationally.
    assign full_q  = (count_q == DEPTH_C);
    assign empty_q = (count_q == '0);

    assign wr_acc = bus.w_en & ~full_q  & ~bus.clr;
    assign rd_acc = bus.r_en & ~empty_q & ~bus.clr;

    assign bus.full         = full_q;
    assign bus.empty        = empty_q;
    assign bus.almost_full  = (count_q >= AF_C);
    assign bus.almost_empty = (count_q <= AE_C);
    assign bus.count        = count_q;
    assign bus.overflow     = overflow_q;
    assign bus.underflow    = underflow_q;

    always_ff @(posedge clk) begin
        if (wr_acc) begin
            mem[wr_ptr] <= bus.w_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            count_q     <= '0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else if (bus.clr) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            count_q     <= '0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            if (wr_acc) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (rd_acc) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({wr_acc, rd_acc})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
            if (bus.w_en && full_q) begin
                overflow_q <= 1'b1;
            end
            if (bus.r_en && empty_q) begin
                underflow_q <= 1'b1;
            end
        end
    end

    if (FWFT == 0) begin : g_reg_read
        logic [DATA_WIDTH-1:0] r_data_q;

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                r_data_q <= '0;
            end else if (rd_acc) begin
                r_data_q <= mem[rd_ptr];
            end
        end

        assign bus.r_data = r_data_q;
    end else begin : g_fwft_read
        // Head word is shown directly; it is only meaningful while the FIFO is not empty.
        assign bus.r_data = mem[rd_ptr];
    end
endmodule

// File: tb/tb_sync_fifo_flags.sv
// tb/tb_sync_fifo_flags.sv - Randomised and directed check of both read modes against a queue model
module tb_sync_fifo_flags;
    localparam int DW = 8;
    localparam int AW = 3;
    localparam int DEPTH = 8;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    sync_fifo_flags_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) if0 ();
    sync_fifo_flags_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) if1 ();

    sync_fifo_flags #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .AF_THRESH(6), .AE_THRESH(1), .FWFT(0))
        u_reg (.clk(clk), .rst_n(rst_n), .bus(if0.slave));
    sync_fifo_flags #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .AF_THRESH(6), .AE_THRESH(1), .FWFT(1))
        u_fwft (.clk(clk), .rst_n(rst_n), .bus(if1.slave));

    int errors = 0;
    int checks = 0;
    bit chk_en = 1'b0;

    logic [DW-1:0] q[$];
    logic          m_ovf = 1'b0;
    logic          m_udf = 1'b0;
    logic [DW-1:0] m_rdata = '0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        q.delete();
        m_ovf   = 1'b0;
        m_udf   = 1'b0;
        m_rdata = '0;
    endtask

    task automatic model_step(input logic w, input logic [DW-1:0] d, input logic r, input logic c);
        int n;
        n = q.size();
        if (c) begin
            q.delete();
            m_ovf = 1'b0;
            m_udf = 1'b0;
        end else begin
            if (w && n == DEPTH) m_ovf = 1'b1;
            if (r && n == 0)     m_udf = 1'b1;
            if (r && n > 0)      m_rdata = q.pop_front();
            if (w && n < DEPTH)  q.push_back(d);
        end
    endtask

    task automatic cyc(input logic w, input logic [DW-1:0] d, input logic r, input logic c);
        if0.w_en = w; if0.w_data = d; if0.r_en = r; if0.clr = c;
        if1.w_en = w; if1.w_data = d; if1.r_en = r; if1.clr = c;
        @(posedge clk);
        model_step(w, d, r, c);
        #1;
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            chk("count",         {28'd0, if0.count},        q.size());
            chk("full",          {31'd0, if0.full},         {31'd0, q.size() == DEPTH});
            chk("empty",         {31'd0, if0.empty},        {31'd0, q.size() == 0});
            chk("almost_full",   {31'd0, if0.almost_full},  {31'd0, q.size() >= 6});
            chk("almost_empty",  {31'd0, if0.almost_empty}, {31'd0, q.size() <= 1});
            chk("overflow",      {31'd0, if0.overflow},     {31'd0, m_ovf});
            chk("underflow",     {31'd0, if0.underflow},    {31'd0, m_udf});
            chk("r_data_reg",    {24'd0, if0.r_data},       {24'd0, m_rdata});
            chk("fwft_count",    {28'd0, if1.count},        q.size());
            chk("fwft_flags",    {30'd0, if1.overflow, if1.underflow}, {30'd0, m_ovf, m_udf});
            if (q.size() > 0) begin
                chk("r_data_fwft", {24'd0, if1.r_data}, {24'd0, q[0]});
            end
        end
    end

    initial begin
        if0.w_en = 0; if0.w_data = '0; if0.r_en = 0; if0.clr = 0;
        if1.w_en = 0; if1.w_data = '0; if1.r_en = 0; if1.clr = 0;
        model_reset();
        #22;
        rst_n = 1'b1;
        #1;
        chk("rst_empty",  {31'd0, if0.empty},        32'd1);
        chk("rst_full",   {31'd0, if0.full},         32'd0);
        chk("rst_count",  {28'd0, if0.count},        32'd0);
        chk("rst_ae",     {31'd0, if0.almost_empty}, 32'd1);
        chk("rst_err",    {30'd0, if0.overflow, if0.underflow}, 32'd0);
        chk("rst_rdata",  {24'd0, if0.r_data},       32'd0);
        chk_en = 1'b1;

        // fill 0x01..0x08
        for (int i = 1; i <= 8; i++) begin
            cyc(1'b1, DW'(i), 1'b0, 1'b0);
            if (i == 5) chk("af_at5", {31'd0, if0.almost_full}, 32'd0);
            if (i == 6) chk("af_at6", {31'd0, if0.almost_full}, 32'd1);
        end
        chk("fill_full",  {31'd0, if0.full},  32'd1);
        chk("fill_count", {28'd0, if0.count}, 32'd8);

        cyc(1'b1, 8'hAA, 1'b0, 1'b0);
        chk("ovf_set",   {31'd0, if0.overflow}, 32'd1);
        chk("ovf_count", {28'd0, if0.count},    32'd8);

        for (int i = 1; i <= 8; i++) begin
            cyc(1'b0, '0, 1'b1, 1'b0);
            chk("drain_data", {24'd0, if0.r_data}, i);
        end
        chk("drain_empty", {31'd0, if0.empty},    32'd1);
        chk("ovf_sticky",  {31'd0, if0.overflow}, 32'd1);

        cyc(1'b1, 8'h33, 1'b0, 1'b0);
        cyc(1'b1, 8'h44, 1'b1, 1'b1);
        chk("clr_ovf",   {31'd0, if0.overflow}, 32'd0);
        chk("clr_count", {28'd0, if0.count},    32'd0);
        chk("clr_empty", {31'd0, if0.empty},    32'd1);

        for (int i = 0; i < 4; i++) cyc(1'b1, DW'(8'h10 + i), 1'b0, 1'b0);
        for (int i = 0; i < 10; i++) begin
            cyc(1'b1, DW'(8'h20 + i), 1'b1, 1'b0);
            chk("simul_count", {28'd0, if0.count}, 32'd4);
        end
        chk("simul_last_read", {24'd0, if0.r_data}, 32'h25);
        for (int i = 0; i < 4; i++) cyc(1'b0, '0, 1'b1, 1'b0);
        cyc(1'b1, 8'h77, 1'b1, 1'b0);
        chk("empty_wr_count", {28'd0, if0.count},     32'd1);
        chk("empty_wr_udf",   {31'd0, if0.underflow}, 32'd1);
        cyc(1'b0, '0, 1'b0, 1'b1);

        cyc(1'b1, 8'h5A, 1'b0, 1'b0);
        chk("fwft_data",  {24'd0, if1.r_data}, 32'h5A);
        chk("fwft_empty", {31'd0, if1.empty},  32'd0);
        cyc(1'b0, '0, 1'b1, 1'b0);
        chk("fwft_pop_empty", {31'd0, if1.empty}, 32'd1);

        for (int i = 0; i < 5; i++) cyc(1'b1, DW'(8'hC0 + i), 1'b0, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_count", {28'd0, if0.count}, 32'd0);
        chk("arst_empty", {31'd0, if0.empty}, 32'd1);
        chk("arst_fwft_count", {28'd0, if1.count}, 32'd0);
        model_reset();
        #1;
        rst_n = 1'b1;

        for (int ph = 0; ph < 4; ph++) begin
            for (int n = 0; n < 600; n++) begin
                logic w, r, c;
                w = ($urandom_range(0, 3) < ((ph == 0) ? 3 : (ph == 1) ? 1 : 2));
                r = ($urandom_range(0, 3) < ((ph == 0) ? 1 : (ph == 1) ? 3 : 2));
                c = ($urandom_range(0, 99) == 0);
                cyc(w, DW'($urandom), r, c);
            end
        end

        @(negedge clk);
        #1;
        chk_en = 1'b0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
